// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg
//   Shared constants for the fetch/execute control-step sequencer:
//   phase encoding, datapath bit positions inside the busSelect/enable
//   vectors, and the ALU op used to increment the PC during T0.
package fetch_seq_pkg;

    // Phase encoding. The numeric values are visible on the phase port.
    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_T0     = 3'd1,
        PH_T1     = 3'd2,
        PH_T2     = 3'd3,
        PH_EXEC   = 3'd4,
        PH_HALTED = 3'd5
    } phase_e;

    // Bus-driver select bit positions (busSelect)
    localparam int PC_OUT  = 20;
    localparam int ZLO_OUT = 19;
    localparam int MDR_OUT = 21;

    // Register load-enable bit positions (enable)
    localparam int MAR_IN  = 25;
    localparam int Z_IN    = 18;
    localparam int PC_IN   = 20;
    localparam int MDR_IN  = 21;
    localparam int IR_IN   = 24;

    // ALU op that produces PC+1 into Z
    localparam int INCPC_OP = 14;

endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Control-step sequencer for the simple datapath. Walks the fetch steps
//   T0 (PC->MAR, PC+1->Z), T1 (Zlow->PC, mem->MDR, stretched by MEM_WAIT
//   cycles) and T2 (MDR->IR), then a variable-length EXEC phase whose
//   length comes from the decoder. Supports run/halt/stall control and
//   counts retired instructions.
//
// Ports
//   clk             in   system clock
//   clr             in   synchronous active-high reset
//   run             in   level; required to leave IDLE or HALTED
//   halt_req        in   level; sampled on the final execute step
//   stall           in   freezes sequencing and suppresses register loads
//   exec_len        in   execute step count, valid from first EXEC cycle
//   busSelect       out  one-hot bus-driver select (fetch steps only)
//   enable          out  register load enables (fetch steps only)
//   Control_Signals out  ALU op (INCPC_OP during T0, else 0)
//   MD_Read         out  MDR mux selects memory data
//   ReadRAM         out  RAM read strobe
//   phase           out  current phase (see phase_e)
//   exec_step       out  current execute step, 0 outside EXEC
//   instr_count     out  retired instruction count (wraps)
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int CTRL_W   = 32,
    parameter int OP_W     = 5,
    parameter int MEM_WAIT = 1,
    parameter int MAX_EXEC = 8,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        run,
    input  logic                        halt_req,
    input  logic                        stall,
    input  logic [$clog2(MAX_EXEC):0]   exec_len,
    output logic [CTRL_W-1:0]           busSelect,
    output logic [CTRL_W-1:0]           enable,
    output logic [OP_W-1:0]             Control_Signals,
    output logic                        MD_Read,
    output logic                        ReadRAM,
    output logic [2:0]                  phase,
    output logic [$clog2(MAX_EXEC)-1:0] exec_step,
    output logic [CNT_W-1:0]            instr_count
);

    localparam int SW = $clog2(MAX_EXEC);
    localparam int LW = SW + 1;
    localparam logic [3:0]    WAIT_INIT = 4'(MEM_WAIT);
    localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_EXEC);

    phase_e        state;
    logic [3:0]    wait_cnt;
    logic [SW-1:0] step_q;
    logic [LW-1:0] len_q;
    logic [CNT_W-1:0] count_q;

    logic [LW-1:0] len_sat;
    logic [LW-1:0] eff_len;
    logic          last_step;
    logic          advance;
    logic [CTRL_W-1:0] en_dec;

    // Decoder length is clamped to 1..MAX_EXEC.
    always_comb begin
        len_sat = exec_len;
        if (exec_len == '0)
            len_sat = LW'(1);
        else if (exec_len > LEN_MAX)
            len_sat = LEN_MAX;
    end

    // exec_len only becomes valid in the first EXEC cycle, so step 0 uses
    // the live input and later steps use the value latched on step 0.
    assign eff_len   = (step_q == '0) ? len_sat : len_q;
    assign last_step = (LW'(step_q) == eff_len - LW'(1));

    // stall is ignored while parked in IDLE/HALTED.
    assign advance = !stall || state == PH_IDLE || state == PH_HALTED;

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= PH_IDLE;
            wait_cnt <= '0;
            step_q   <= '0;
            len_q    <= '0;
            count_q  <= '0;
        end else if (advance) begin
            case (state)
                PH_IDLE: begin
                    if (run) state <= PH_T0;
                end
                PH_T0: begin
                    state    <= PH_T1;
                    wait_cnt <= WAIT_INIT;
                end
                PH_T1: begin
                    if (wait_cnt == '0)
                        state <= PH_T2;
                    else
                        wait_cnt <= wait_cnt - 4'd1;
                end
                PH_T2: begin
                    state  <= PH_EXEC;
                    step_q <= '0;
                end
                PH_EXEC: begin
                    if (step_q == '0) len_q <= len_sat;
                    if (last_step) begin
                        count_q <= count_q + CNT_W'(1);
                        step_q  <= '0;
                        state   <= halt_req ? PH_HALTED : PH_T0;
                    end else begin
                        step_q <= step_q + SW'(1);
                    end
                end
                PH_HALTED: begin
                    if (run && !halt_req) state <= PH_T0;
                end
                default: state <= PH_IDLE;
            endcase
        end
    end

    // Moore decode from the state register.
    always_comb begin
        busSelect       = '0;
        en_dec          = '0;
        Control_Signals = '0;
        MD_Read         = 1'b0;
        ReadRAM         = 1'b0;
        case (state)
            PH_T0: begin
                busSelect[PC_OUT] = 1'b1;
                en_dec[MAR_IN]    = 1'b1;
                en_dec[Z_IN]      = 1'b1;
                Control_Signals   = OP_W'(INCPC_OP);
            end
            PH_T1: begin
                busSelect[ZLO_OUT] = 1'b1;
                en_dec[MDR_IN]     = 1'b1;
                // Counter still holds its reload value only on the first
                // T1 cycle, so the PC is written exactly once.
                en_dec[PC_IN]      = (wait_cnt == WAIT_INIT);
                MD_Read            = 1'b1;
                ReadRAM            = 1'b1;
            end
            PH_T2: begin
                busSelect[MDR_OUT] = 1'b1;
                en_dec[IR_IN]      = 1'b1;
            end
            default: ;
        endcase
    end

    // A stalled cycle must not write any register.
    assign enable      = stall ? '0 : en_dec;
    assign phase       = state;
    assign exec_step   = step_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default parameters
    logic        clr = 1'b1, run = 1'b0, halt_req = 1'b0, stall = 1'b0;
    logic [3:0]  exec_len = '0;
    logic [31:0] busSelect, enable;
    logic [4:0]  Control_Signals;
    logic        MD_Read, ReadRAM;
    logic [2:0]  phase, exec_step;
    logic [15:0] instr_count;

    fetch_sequencer dut (
        .clk(clk), .clr(clr), .run(run), .halt_req(halt_req), .stall(stall),
        .exec_len(exec_len), .busSelect(busSelect), .enable(enable),
        .Control_Signals(Control_Signals), .MD_Read(MD_Read), .ReadRAM(ReadRAM),
        .phase(phase), .exec_step(exec_step), .instr_count(instr_count)
    );

    // DUT B: no memory wait, 4-bit counter to observe the wrap
    logic        clr_b = 1'b1, run_b = 1'b0, halt_b = 1'b0, stall_b = 1'b0;
    logic [3:0]  len_b = '0;
    logic [31:0] bus_b, en_b;
    logic [4:0]  ctl_b;
    logic        mdr_b, rr_b;
    logic [2:0]  ph_b, stp_b;
    logic [3:0]  cnt_b;

    fetch_sequencer #(.MEM_WAIT(0), .CNT_W(4)) dut_b (
        .clk(clk), .clr(clr_b), .run(run_b), .halt_req(halt_b), .stall(stall_b),
        .exec_len(len_b), .busSelect(bus_b), .enable(en_b),
        .Control_Signals(ctl_b), .MD_Read(mdr_b), .ReadRAM(rr_b),
        .phase(ph_b), .exec_step(stp_b), .instr_count(cnt_b)
    );

    typedef struct {
        bit clr, run, stall, halt;
        int len;
        int ph, stp, cnt;
        bit pcin;
    } vec_t;

    typedef struct {
        int ph, stp, cnt;
        logic [31:0] bus, en;
        int ctrl;
        bit md, rr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic v(input bit c, input bit r, input bit s, input bit h,
                     input int len, input int ph, input int stp,
                     input bit pcin, input int cnt);
        vec_t t;
        t.clr = c; t.run = r; t.stall = s; t.halt = h; t.len = len;
        t.ph = ph; t.stp = stp; t.pcin = pcin; t.cnt = cnt;
        vecs.push_back(t);
    endtask

    // Expected control vectors straight from the control-step table.
    function automatic exp_t mk(input vec_t t);
        exp_t e;
        e.ph = t.ph; e.stp = t.stp; e.cnt = t.cnt;
        e.bus = '0; e.en = '0; e.ctrl = 0; e.md = 0; e.rr = 0;
        case (t.ph)
            1: begin e.bus[20] = 1; e.en[25] = 1; e.en[18] = 1; e.ctrl = 14; end
            2: begin e.bus[19] = 1; e.en[21] = 1; e.en[20] = t.pcin; e.md = 1; e.rr = 1; end
            3: begin e.bus[21] = 1; e.en[24] = 1; end
            default: ;
        endcase
        if (t.stall) e.en = '0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // idle after reset
        repeat (5) v(0,0,0,0,0, 0,0,0,0);
        // single instruction, MEM_WAIT=1, exec_len=3
        v(0,1,0,0,3, 0,0,0,0);
        v(0,1,0,0,3, 1,0,0,0);
        v(0,1,0,0,3, 2,0,1,0);
        v(0,1,0,0,3, 2,0,0,0);
        v(0,1,0,0,3, 3,0,0,0);
        v(0,1,0,0,3, 4,0,0,0);
        v(0,1,0,0,3, 4,1,0,0);
        v(0,1,0,0,3, 4,2,0,0);
        // second instruction: 3-cycle stall in second T1 cycle, then halt
        v(0,0,0,0,0, 1,0,0,1);
        v(0,0,0,0,0, 2,0,1,1);
        repeat (3) v(0,0,1,0,0, 2,0,0,1);
        v(0,0,0,0,0, 2,0,0,1);
        v(0,0,0,0,0, 3,0,0,1);
        v(0,0,0,1,0, 4,0,0,1);
        v(0,0,0,0,0, 5,0,0,2);
        v(0,1,0,1,0, 5,0,0,2);
        v(0,1,0,0,0, 5,0,0,2);
        // third instruction: exec_len=15 saturates to 8, later len ignored
        v(0,0,0,0,15, 1,0,0,2);
        v(0,0,0,0,15, 2,0,1,2);
        v(0,0,0,0,15, 2,0,0,2);
        v(0,0,0,0,15, 3,0,0,2);
        v(0,0,0,0,15, 4,0,0,2);
        for (int s = 1; s < 7; s++) v(0,0,0,0,1, 4,s,0,2);
        v(0,0,1,1,1, 4,7,0,2);   // stalled last step: no count, no halt
        v(0,0,0,0,1, 4,7,0,2);
        // fourth instruction: reset at exec_step 2
        v(0,0,0,0,4, 1,0,0,3);
        v(0,0,0,0,4, 2,0,1,3);
        v(0,0,0,0,4, 2,0,0,3);
        v(0,0,0,0,4, 3,0,0,3);
        v(0,0,0,0,4, 4,0,0,3);
        v(0,0,0,0,4, 4,1,0,3);
        v(1,0,0,0,4, 4,2,0,3);
        v(0,0,0,0,0, 0,0,0,0);
        // stall in IDLE is ignored
        v(0,1,1,0,0, 0,0,0,0);
        v(0,0,0,0,0, 1,0,0,0);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            clr = vecs[i].clr; run = vecs[i].run; stall = vecs[i].stall;
            halt_req = vecs[i].halt; exec_len = 4'(vecs[i].len);
            sb.push_back(mk(vecs[i]));
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("v%0d phase", i),   32'(phase), 32'(e.ph));
            chk($sformatf("v%0d step", i),    32'(exec_step), 32'(e.stp));
            chk($sformatf("v%0d count", i),   32'(instr_count), 32'(e.cnt));
            chk($sformatf("v%0d bus", i),     busSelect, e.bus);
            chk($sformatf("v%0d enable", i),  enable, e.en);
            chk($sformatf("v%0d ctrl", i),    32'(Control_Signals), 32'(e.ctrl));
            chk($sformatf("v%0d mdread", i),  32'(MD_Read), 32'(e.md));
            chk($sformatf("v%0d readram", i), 32'(ReadRAM), 32'(e.rr));
            chk($sformatf("v%0d onehot", i),  32'($countones(busSelect) <= 1), 32'd1);
            @(posedge clk);
            #1;
        end

        // DUT B: MEM_WAIT=0, exec_len=0 -> 4 cycles per instruction,
        // 17 instructions so the 4-bit count wraps back to 0.
        clr_b = 1'b0; run_b = 1'b1; len_b = '0;
        @(negedge clk);
        chk("b idle phase", 32'(ph_b), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 68; i++) begin
            exp_t e;
            e.ph = (i % 4) + 1; e.stp = 0; e.cnt = (i / 4) % 16;
            e.bus = '0; e.en = '0; e.ctrl = 0; e.md = 0; e.rr = 0;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("b%0d phase", i), 32'(ph_b), 32'(e.ph));
            chk($sformatf("b%0d count", i), 32'(cnt_b), 32'(e.cnt));
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
